div_sqrt_preproc_mvp: RTL and testbench

- Operand pre-processing stage directly upstream of the div/sqrt iteration unit.
- Accepts raw IEEE operands in FP64, FP32, FP16 or FP16alt and unpacks sign, exponent and mantissa.
- Normalises denormal inputs and resolves special cases (NaN/Inf/zero/negative sqrt) into a ready-made result and flags.
- Presents the result through a valid/ready handshake to the iteration unit.

---
 rtl/div_sqrt_preproc_mvp_pkg.sv | 122 ++++++++++++
 rtl/div_sqrt_lzc_mvp.sv | 20 ++
 rtl/div_sqrt_preproc_mvp.sv | 253 +++++++++++++++++++++++++
 tb/tb_div_sqrt_preproc_mvp.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_sqrt_preproc_mvp_pkg.sv
// Shared constants, types and field helpers for the div/sqrt operand pre-processing stage.
// Covers FP64/FP32/FP16/FP16alt layouts, special-value encodings and FSM states.
package div_sqrt_preproc_mvp_pkg;

  localparam logic [1:0] FMT_FP32    = 2'b00;
  localparam logic [1:0] FMT_FP64    = 2'b01;
  localparam logic [1:0] FMT_FP16    = 2'b10;
  localparam logic [1:0] FMT_FP16ALT = 2'b11;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NORM = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  localparam int unsigned C_EXP_FP64    = 11;
  localparam int unsigned C_MANT_FP64   = 52;
  localparam int unsigned C_EXP_FP32    = 8;
  localparam int unsigned C_MANT_FP32   = 23;
  localparam int unsigned C_EXP_FP16    = 5;
  localparam int unsigned C_MANT_FP16   = 10;
  localparam int unsigned C_EXP_FP16ALT = 8;
  localparam int unsigned C_MANT_FP16ALT = 7;

  localparam int unsigned C_BIAS_FP64    = 1023;
  localparam int unsigned C_BIAS_FP32    = 127;
  localparam int unsigned C_BIAS_FP16    = 15;
  localparam int unsigned C_BIAS_FP16ALT = 127;

  localparam logic [63:0] C_QNAN_FP64    = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] C_QNAN_FP32    = 64'h0000_0000_7FC0_0000;
  localparam logic [63:0] C_QNAN_FP16    = 64'h0000_0000_0000_7E00;
  localparam logic [63:0] C_QNAN_FP16ALT = 64'h0000_0000_0000_7FC0;

  localparam int unsigned FRAC_W    = 52;
  localparam int unsigned EFF_EXP_W = 11;
  localparam int unsigned LZC_W     = 53;
  localparam int unsigned CNT_W     = 6;

  typedef struct packed {
    logic nan;
    logic snan;
    logic inf;
    logic zero;
  } fp_class_t;

  typedef struct packed {
    logic                 sign;
    logic                 hidden;
    logic [EFF_EXP_W-1:0] exp_eff;
    logic [FRAC_W-1:0]    frac;   // fraction left-aligned at bit FRAC_W-1
    fp_class_t            cls;
  } fp_unpacked_t;

  // Split a right-aligned operand into sign, effective exponent and left-aligned fraction.
  function automatic fp_unpacked_t fp_unpack(input logic [1:0] fmt, input logic [63:0] op);
    fp_unpacked_t         u;
    logic [EFF_EXP_W-1:0] e;
    logic                 emax;
    u    = '0;
    e    = '0;
    emax = 1'b0;
    case (fmt)
      FMT_FP64: begin
        u.sign = op[C_MANT_FP64 + C_EXP_FP64];
        e      = op[C_MANT_FP64 +: C_EXP_FP64];
        u.frac = op[C_MANT_FP64-1:0];
        emax   = &op[C_MANT_FP64 +: C_EXP_FP64];
      end
      FMT_FP32: begin
        u.sign = op[C_MANT_FP32 + C_EXP_FP32];
        e      = EFF_EXP_W'(op[C_MANT_FP32 +: C_EXP_FP32]);
        u.frac = {op[C_MANT_FP32-1:0], 29'd0};
        emax   = &op[C_MANT_FP32 +: C_EXP_FP32];
      end
      FMT_FP16: begin
        u.sign = op[C_MANT_FP16 + C_EXP_FP16];
        e      = EFF_EXP_W'(op[C_MANT_FP16 +: C_EXP_FP16]);
        u.frac = {op[C_MANT_FP16-1:0], 42'd0};
        emax   = &op[C_MANT_FP16 +: C_EXP_FP16];
      end
      default: begin
        u.sign = op[C_MANT_FP16ALT + C_EXP_FP16ALT];
        e      = EFF_EXP_W'(op[C_MANT_FP16ALT +: C_EXP_FP16ALT]);
        u.frac = {op[C_MANT_FP16ALT-1:0], 45'd0};
        emax   = &op[C_MANT_FP16ALT +: C_EXP_FP16ALT];
      end
    endcase
    u.hidden     = |e;
    u.exp_eff    = u.hidden ? e : EFF_EXP_W'(1);
    u.cls.zero   = ~u.hidden & ~|u.frac;
    u.cls.inf    = emax & ~|u.frac;
    u.cls.nan    = emax & |u.frac;
    u.cls.snan   = u.cls.nan & ~u.frac[FRAC_W-1];
    return u;
  endfunction

  function automatic logic [63:0] fp_qnan(input logic [1:0] fmt);
    case (fmt)
      FMT_FP64: return C_QNAN_FP64;
      FMT_FP32: return C_QNAN_FP32;
      FMT_FP16: return C_QNAN_FP16;
      default:  return C_QNAN_FP16ALT;
    endcase
  endfunction

  function automatic logic [63:0] fp_inf(input logic [1:0] fmt, input logic sign);
    case (fmt)
      FMT_FP64: return {sign, 11'h7FF, 52'd0};
      FMT_FP32: return {32'd0, sign, 8'hFF, 23'd0};
      FMT_FP16: return {48'd0, sign, 5'h1F, 10'd0};
      default:  return {48'd0, sign, 8'hFF, 7'd0};
    endcase
  endfunction

  function automatic logic [63:0] fp_zero(input logic [1:0] fmt, input logic sign);
    case (fmt)
      FMT_FP64: return {sign, 63'd0};
      FMT_FP32: return {32'd0, sign, 31'd0};
      default:  return {48'd0, sign, 15'd0};
    endcase
  endfunction

endpackage

// File: rtl/div_sqrt_lzc_mvp.sv
// Combinational 53-bit leading-zero counter; count is 53 and all_zero set for a zero input.
module div_sqrt_lzc_mvp
  import div_sqrt_preproc_mvp_pkg::*;
(
  input  logic [LZC_W-1:0] in_i,
  output logic [CNT_W-1:0] cnt_c_o,
  output logic             all_zero_c_o
);

  // Scan upward so the highest set bit is the last (winning) assignment.
  always_comb begin
    cnt_c_o = CNT_W'(LZC_W);
    for (int i = 0; i < int'(LZC_W); i++) begin
      if (in_i[i]) cnt_c_o = CNT_W'(int'(LZC_W) - 1 - i);
    end
  end

  assign all_zero_c_o = ~|in_i;

endmodule

// File: rtl/div_sqrt_preproc_mvp.sv
// Operand pre-processing for the div/sqrt iteration unit: unpack, normalise denormals,
// resolve special cases, and hand off through a valid/ready handshake.
module div_sqrt_preproc_mvp
  import div_sqrt_preproc_mvp_pkg::*;
#(
  parameter int unsigned EXP_W  = 13,
  parameter int unsigned MANT_W = 53
) (
  input  logic              Clk_CI,
  input  logic              Rst_RBI,
  input  logic              Div_start_SI,
  input  logic              Sqrt_start_SI,
  input  logic              Kill_SI,
  input  logic [63:0]       Operand_a_DI,
  input  logic [63:0]       Operand_b_DI,
  input  logic [2:0]        RM_SI,
  input  logic [5:0]        Precision_ctl_SI,
  input  logic [1:0]        Format_sel_SI,
  output logic              Ready_SO,
  output logic              Out_valid_SO,
  input  logic              Out_ready_SI,
  output logic              Is_div_SO,
  output logic              Sign_a_DO,
  output logic              Sign_b_DO,
  output logic [EXP_W-1:0]  Exp_a_DO,
  output logic [EXP_W-1:0]  Exp_b_DO,
  output logic [MANT_W-1:0] Mant_a_DO,
  output logic [MANT_W-1:0] Mant_b_DO,
  output logic              Special_SO,
  output logic [63:0]       Special_res_DO,
  output logic              NV_SO,
  output logic              DZ_SO,
  output logic [2:0]        RM_SO,
  output logic [5:0]        Precision_ctl_SO,
  output logic [1:0]        Format_sel_SO
);

  logic [1:0] state_q, state_d;
  logic       valid_q, valid_d;
  logic       ready_q, ready_d;
  logic       accept_c, load_c;

  logic        req_div_q;
  logic [63:0] op_a_q, op_b_q;
  logic [2:0]  rm_q;
  logic [5:0]  prec_q;
  logic [1:0]  fmt_q;

  logic              is_div_q, sign_a_q, sign_b_q;
  logic [EXP_W-1:0]  exp_a_q, exp_b_q;
  logic [MANT_W-1:0] mant_a_q, mant_b_q;
  logic              special_q, nv_q, dz_q;
  logic [63:0]       res_q;
  logic [2:0]        rm_out_q;
  logic [5:0]        prec_out_q;
  logic [1:0]        fmt_out_q;

  // FSM next state; kill overrides both start and downstream ready.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    load_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Div_start_SI || Sqrt_start_SI) begin
          accept_c = 1'b1;
          state_d  = NORM;
        end
      end
      NORM: begin
        load_c  = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (Out_ready_SI) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (Kill_SI) begin
      state_d  = IDLE;
      accept_c = 1'b0;
      load_c   = 1'b0;
    end
    valid_d = (state_d == OUT);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  fp_unpacked_t      ua_c, ub_c;
  logic [CNT_W-1:0]  cnt_a_c, cnt_b_c;
  logic              zero_a_c, zero_b_c;
  logic [MANT_W-1:0] raw_mant_a_c, raw_mant_b_c;
  logic [MANT_W-1:0] norm_mant_a_c, norm_mant_b_c;
  logic [EXP_W-1:0]  norm_exp_a_c, norm_exp_b_c;

  assign ua_c = fp_unpack(fmt_q, op_a_q);
  assign ub_c = fp_unpack(fmt_q, op_b_q);

  assign raw_mant_a_c = MANT_W'({ua_c.hidden, ua_c.frac});
  assign raw_mant_b_c = MANT_W'({ub_c.hidden, ub_c.frac});

  div_sqrt_lzc_mvp u_lzc_a (
    .in_i         (LZC_W'(raw_mant_a_c)),
    .cnt_c_o      (cnt_a_c),
    .all_zero_c_o (zero_a_c)
  );

  div_sqrt_lzc_mvp u_lzc_b (
    .in_i         (LZC_W'(raw_mant_b_c)),
    .cnt_c_o      (cnt_b_c),
    .all_zero_c_o (zero_b_c)
  );

  // Denormals end up with a negative two's-complement exponent after the shift.
  assign norm_mant_a_c = zero_a_c ? '0 : raw_mant_a_c << cnt_a_c;
  assign norm_mant_b_c = zero_b_c ? '0 : raw_mant_b_c << cnt_b_c;
  assign norm_exp_a_c  = zero_a_c ? '0 : EXP_W'(ua_c.exp_eff) - EXP_W'(cnt_a_c);
  assign norm_exp_b_c  = zero_b_c ? '0 : EXP_W'(ub_c.exp_eff) - EXP_W'(cnt_b_c);

  logic        special_c, nv_c, dz_c;
  logic [63:0] res_c;
  logic        sx_c;

  assign sx_c = ua_c.sign ^ ub_c.sign;

  // Special-case resolution; branch order encodes the priority between cases.
  always_comb begin
    special_c = 1'b0;
    res_c     = '0;
    nv_c      = 1'b0;
    dz_c      = 1'b0;
    if (req_div_q) begin
      if (ua_c.cls.nan || ub_c.cls.nan) begin
        special_c = 1'b1;
        res_c     = fp_qnan(fmt_q);
        nv_c      = ua_c.cls.snan | ub_c.cls.snan;
      end else if ((ua_c.cls.inf && ub_c.cls.inf) || (ua_c.cls.zero && ub_c.cls.zero)) begin
        special_c = 1'b1;
        res_c     = fp_qnan(fmt_q);
        nv_c      = 1'b1;
      end else if (ua_c.cls.inf) begin
        special_c = 1'b1;
        res_c     = fp_inf(fmt_q, sx_c);
      end else if (ub_c.cls.inf) begin
        special_c = 1'b1;
        res_c     = fp_zero(fmt_q, sx_c);
      end else if (ub_c.cls.zero) begin
        special_c = 1'b1;
        res_c     = fp_inf(fmt_q, sx_c);
        dz_c      = 1'b1;
      end else if (ua_c.cls.zero) begin
        special_c = 1'b1;
        res_c     = fp_zero(fmt_q, sx_c);
      end
    end else begin
      if (ua_c.cls.nan) begin
        special_c = 1'b1;
        res_c     = fp_qnan(fmt_q);
        nv_c      = ua_c.cls.snan;
      end else if (ua_c.cls.zero) begin
        special_c = 1'b1;
        res_c     = fp_zero(fmt_q, ua_c.sign);
      end else if (ua_c.sign) begin
        special_c = 1'b1;
        res_c     = fp_qnan(fmt_q);
        nv_c      = 1'b1;
      end else if (ua_c.cls.inf) begin
        special_c = 1'b1;
        res_c     = fp_inf(fmt_q, 1'b0);
      end
    end
  end

  // Request capture on accept, result registers loaded once in NORM and held through OUT.
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      req_div_q  <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      rm_q       <= '0;
      prec_q     <= '0;
      fmt_q      <= '0;
      is_div_q   <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      exp_a_q    <= '0;
      exp_b_q    <= '0;
      mant_a_q   <= '0;
      mant_b_q   <= '0;
      special_q  <= 1'b0;
      res_q      <= '0;
      nv_q       <= 1'b0;
      dz_q       <= 1'b0;
      rm_out_q   <= '0;
      prec_out_q <= '0;
      fmt_out_q  <= '0;
    end else begin
      if (accept_c) begin
        req_div_q <= Div_start_SI;
        op_a_q    <= Operand_a_DI;
        op_b_q    <= Operand_b_DI;
        rm_q      <= RM_SI;
        prec_q    <= Precision_ctl_SI;
        fmt_q     <= Format_sel_SI;
      end
      if (load_c) begin
        is_div_q   <= req_div_q;
        sign_a_q   <= ua_c.sign;
        sign_b_q   <= ub_c.sign;
        exp_a_q    <= norm_exp_a_c;
        exp_b_q    <= norm_exp_b_c;
        mant_a_q   <= norm_mant_a_c;
        mant_b_q   <= norm_mant_b_c;
        special_q  <= special_c;
        res_q      <= res_c;
        nv_q       <= nv_c;
        dz_q       <= dz_c;
        rm_out_q   <= rm_q;
        prec_out_q <= prec_q;
        fmt_out_q  <= fmt_q;
      end
    end
  end

  assign Ready_SO         = ready_q;
  assign Out_valid_SO     = valid_q;
  assign Is_div_SO        = is_div_q;
  assign Sign_a_DO        = sign_a_q;
  assign Sign_b_DO        = sign_b_q;
  assign Exp_a_DO         = exp_a_q;
  assign Exp_b_DO         = exp_b_q;
  assign Mant_a_DO        = mant_a_q;
  assign Mant_b_DO        = mant_b_q;
  assign Special_SO       = special_q;
  assign Special_res_DO   = res_q;
  assign NV_SO            = nv_q;
  assign DZ_SO            = dz_q;
  assign RM_SO            = rm_out_q;
  assign Precision_ctl_SO = prec_out_q;
  assign Format_sel_SO    = fmt_out_q;

endmodule

// File: tb/tb_div_sqrt_preproc_mvp.sv
// Self-checking bench for div_sqrt_preproc_mvp: directed cases plus randomized operations
// compared against an arithmetic reference model of unpacking, normalisation and specials.
module tb_div_sqrt_preproc_mvp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        div_start, sqrt_start, kill;
  logic [63:0] op_a, op_b;
  logic [2:0]  rm;
  logic [5:0]  prec;
  logic [1:0]  fmt;
  logic        ready, out_valid, out_ready;
  logic        is_div, sign_a, sign_b;
  logic [12:0] exp_a, exp_b;
  logic [52:0] mant_a, mant_b;
  logic        special, nv, dz;
  logic [63:0] res;
  logic [2:0]  rm_o;
  logic [5:0]  prec_o;
  logic [1:0]  fmt_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_sqrt_preproc_mvp dut (
    .Clk_CI           (clk),
    .Rst_RBI          (rst_n),
    .Div_start_SI     (div_start),
    .Sqrt_start_SI    (sqrt_start),
    .Kill_SI          (kill),
    .Operand_a_DI     (op_a),
    .Operand_b_DI     (op_b),
    .RM_SI            (rm),
    .Precision_ctl_SI (prec),
    .Format_sel_SI    (fmt),
    .Ready_SO         (ready),
    .Out_valid_SO     (out_valid),
    .Out_ready_SI     (out_ready),
    .Is_div_SO        (is_div),
    .Sign_a_DO        (sign_a),
    .Sign_b_DO        (sign_b),
    .Exp_a_DO         (exp_a),
    .Exp_b_DO         (exp_b),
    .Mant_a_DO        (mant_a),
    .Mant_b_DO        (mant_b),
    .Special_SO       (special),
    .Special_res_DO   (res),
    .NV_SO            (nv),
    .DZ_SO            (dz),
    .RM_SO            (rm_o),
    .Precision_ctl_SO (prec_o),
    .Format_sel_SO    (fmt_o)
  );

  typedef struct {
    logic        sa, sb;
    logic [12:0] ea, eb;
    logic [52:0] ma, mb;
    logic        sp;
    logic [63:0] res;
    logic        nv, dz;
  } exp_t;

  typedef struct {
    logic        en;
    logic [12:0] ea;
    logic [52:0] ma;
    logic        sp;
    logic [63:0] res;
    logic        nv, dz;
  } fix_t;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic void fmt_w(input logic [1:0] f, output int ew, output int fw);
    case (f)
      2'b00:   begin ew = 8;  fw = 23; end
      2'b01:   begin ew = 11; fw = 52; end
      2'b10:   begin ew = 5;  fw = 10; end
      default: begin ew = 8;  fw = 7;  end
    endcase
  endfunction

  // Reference unpack: normalise by repeated doubling until the leading bit reaches bit 52.
  function automatic void ref_unpack(input logic [1:0] f, input logic [63:0] op,
                                     output logic s, output logic [12:0] e, output logic [52:0] m,
                                     output logic is_nan, output logic is_snan,
                                     output logic is_inf, output logic is_zero);
    int ew, fw;
    logic [63:0] re, fr, emax;
    fmt_w(f, ew, fw);
    emax    = (64'd1 << ew) - 64'd1;
    re      = (op >> fw) & emax;
    fr      = op & ((64'd1 << fw) - 64'd1);
    s       = op[ew + fw];
    is_nan  = (re == emax) && (fr != 0);
    is_snan = is_nan && !fr[fw - 1];
    is_inf  = (re == emax) && (fr == 0);
    is_zero = (re == 0) && (fr == 0);
    if (is_zero) begin
      e = '0;
      m = '0;
    end else begin
      m     = 53'(fr << (52 - fw));
      m[52] = (re != 0);
      e     = (re == 0) ? 13'd1 : 13'(re);
      while (!m[52]) begin
        m = m << 1;
        e = e - 13'd1;
      end
    end
  endfunction

  function automatic exp_t model(input logic d, input logic [63:0] a, input logic [63:0] b,
                                 input logic [1:0] f);
    exp_t r;
    int ew, fw;
    logic na, sna, ia, za, nb, snb, ib, zb, sx;
    logic [63:0] qnan, infv, zerov;
    ref_unpack(f, a, r.sa, r.ea, r.ma, na, sna, ia, za);
    ref_unpack(f, b, r.sb, r.eb, r.mb, nb, snb, ib, zb);
    fmt_w(f, ew, fw);
    sx    = d ? (r.sa ^ r.sb) : r.sa;
    qnan  = (((64'd1 << ew) - 64'd1) << fw) | (64'd1 << (fw - 1));
    infv  = (((64'd1 << ew) - 64'd1) << fw) | (64'(sx) << (ew + fw));
    zerov = 64'(sx) << (ew + fw);
    r.sp = 1'b0; r.res = '0; r.nv = 1'b0; r.dz = 1'b0;
    if (d) begin
      if (na || nb)                   begin r.sp = 1; r.res = qnan;  r.nv = sna | snb; end
      else if ((ia && ib) || (za && zb)) begin r.sp = 1; r.res = qnan; r.nv = 1; end
      else if (ia)                    begin r.sp = 1; r.res = infv; end
      else if (ib)                    begin r.sp = 1; r.res = zerov; end
      else if (zb)                    begin r.sp = 1; r.res = infv;  r.dz = 1; end
      else if (za)                    begin r.sp = 1; r.res = zerov; end
    end else begin
      if (na)                         begin r.sp = 1; r.res = qnan;  r.nv = sna; end
      else if (za)                    begin r.sp = 1; r.res = zerov; end
      else if (r.sa)                  begin r.sp = 1; r.res = qnan;  r.nv = 1; end
      else if (ia)                    begin r.sp = 1; r.res = infv; end
    end
    return r;
  endfunction

  // Random operand biased toward zero/max exponents and zero/quiet-bit fractions.
  function automatic logic [63:0] rand_op(input logic [1:0] f);
    int ew, fw;
    logic [63:0] emax, e, fr, r;
    fmt_w(f, ew, fw);
    emax = (64'd1 << ew) - 64'd1;
    case ($urandom_range(0, 5))
      0:       e = 64'd0;
      1:       e = emax;
      default: e = {32'd0, $urandom} % (emax + 64'd1);
    endcase
    case ($urandom_range(0, 4))
      0:       fr = 64'd0;
      1:       fr = 64'd1;
      2:       fr = 64'd1 << (fw - 1);
      default: fr = {$urandom, $urandom} & ((64'd1 << fw) - 64'd1);
    endcase
    r = (e << fw) | fr;
    r[ew + fw] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic compare_out(input string tag, input logic d, input exp_t e,
                             input logic [1:0] f, input logic [2:0] r, input logic [5:0] p);
    check({tag, ".valid"},   64'(out_valid), 64'd1);
    check({tag, ".ready"},   64'(ready),     64'd0);
    check({tag, ".is_div"},  64'(is_div),    64'(d));
    check({tag, ".sign_a"},  64'(sign_a),    64'(e.sa));
    check({tag, ".exp_a"},   64'(exp_a),     64'(e.ea));
    check({tag, ".mant_a"},  64'(mant_a),    64'(e.ma));
    check({tag, ".special"}, 64'(special),   64'(e.sp));
    check({tag, ".res"},     res,            e.res);
    check({tag, ".nv"},      64'(nv),        64'(e.nv));
    check({tag, ".dz"},      64'(dz),        64'(e.dz));
    check({tag, ".rm"},      64'(rm_o),      64'(r));
    check({tag, ".prec"},    64'(prec_o),    64'(p));
    check({tag, ".fmt"},     64'(fmt_o),     64'(f));
    if (d) begin
      check({tag, ".sign_b"}, 64'(sign_b), 64'(e.sb));
      check({tag, ".exp_b"},  64'(exp_b),  64'(e.eb));
      check({tag, ".mant_b"}, 64'(mant_b), 64'(e.mb));
    end
  endtask

  // Full operation: start, two-cycle latency check, optional backpressure, handshake.
  task automatic run_op(input string tag, input logic d, input logic s,
                        input logic [63:0] a, input logic [63:0] b, input logic [1:0] f,
                        input int hold, input fix_t fx);
    exp_t e;
    logic eff_div;
    logic [2:0] r;
    logic [5:0] p;
    eff_div = d;
    e = model(eff_div, a, b, f);
    r = 3'($urandom);
    p = 6'($urandom);
    div_start = d; sqrt_start = s; op_a = a; op_b = b; fmt = f; rm = r; prec = p;
    @(negedge clk);
    div_start = 1'b0; sqrt_start = 1'b0;
    op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
    fmt = 2'($urandom); rm = 3'($urandom); prec = 6'($urandom);
    check({tag, ".lat_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".lat_ready"}, 64'(ready),     64'd0);
    @(negedge clk);
    compare_out(tag, eff_div, e, f, r, p);
    if (fx.en) begin
      check({tag, ".fix_exp_a"},  64'(exp_a),   64'(fx.ea));
      check({tag, ".fix_mant_a"}, 64'(mant_a),  64'(fx.ma));
      check({tag, ".fix_special"},64'(special), 64'(fx.sp));
      check({tag, ".fix_res"},    res,          fx.res);
      check({tag, ".fix_nv"},     64'(nv),      64'(fx.nv));
      check({tag, ".fix_dz"},     64'(dz),      64'(fx.dz));
    end
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        div_start = 1'b1; sqrt_start = 1'b1; op_a = {$urandom, $urandom};
      end else begin
        div_start = 1'b0; sqrt_start = 1'b0;
      end
      @(negedge clk);
      check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, ".hold_ready"}, 64'(ready),     64'd0);
      check({tag, ".hold_exp_a"}, 64'(exp_a),     64'(e.ea));
      check({tag, ".hold_mant_a"},64'(mant_a),    64'(e.ma));
      check({tag, ".hold_res"},   res,            e.res);
      check({tag, ".hold_is_div"},64'(is_div),    64'(eff_div));
    end
    div_start = 1'b0; sqrt_start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".done_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".done_ready"}, 64'(ready),     64'd1);
  endtask

  task automatic kill_test(input string tag, input int at_cycle, input logic both);
    div_start = 1'b1; sqrt_start = both; op_a = 64'h3F80_0000; op_b = 64'h4000_0000;
    fmt = 2'b00;
    @(negedge clk);
    div_start = 1'b0; sqrt_start = 1'b0;
    if (at_cycle == 1) @(negedge clk);
    kill = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    kill = 1'b0;
    check({tag, ".valid"}, 64'(out_valid), 64'd0);
    check({tag, ".ready"}, 64'(ready),     64'd1);
    @(negedge clk);
    check({tag, ".stay_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".stay_ready"}, 64'(ready),     64'd1);
  endtask

  fix_t nofix;
  fix_t fx;

  initial begin
    rst_n = 1'b0; div_start = 1'b0; sqrt_start = 1'b0; kill = 1'b0;
    op_a = '0; op_b = '0; rm = '0; prec = '0; fmt = '0; out_ready = 1'b0;
    nofix = '{en: 1'b0, ea: '0, ma: '0, sp: 1'b0, res: '0, nv: 1'b0, dz: 1'b0};
    repeat (3) @(negedge clk);
    check("rst.ready",   64'(ready),     64'd1);
    check("rst.valid",   64'(out_valid), 64'd0);
    check("rst.is_div",  64'(is_div),    64'd0);
    check("rst.special", 64'(special),   64'd0);
    check("rst.exp_a",   64'(exp_a),     64'd0);
    check("rst.mant_a",  64'(mant_a),    64'd0);
    check("rst.res",     res,            64'd0);
    check("rst.rm",      64'(rm_o),      64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    fx = '{en: 1'b1, ea: 13'd127, ma: 53'd1 << 52, sp: 1'b0, res: '0, nv: 1'b0, dz: 1'b0};
    run_op("fp32_div_1_2", 1'b1, 1'b0, 64'h3F80_0000, 64'h4000_0000, 2'b00, 0, fx);
    fx = '{en: 1'b1, ea: 13'h1FEA, ma: 53'd1 << 52, sp: 1'b0, res: '0, nv: 1'b0, dz: 1'b0};
    run_op("fp32_sqrt_denorm", 1'b0, 1'b1, 64'h0000_0001, 64'd0, 2'b00, 0, fx);
    fx = '{en: 1'b1, ea: 13'h401, ma: 53'd1 << 52, sp: 1'b1, res: 64'h7FF8_0000_0000_0000,
           nv: 1'b1, dz: 1'b0};
    run_op("fp64_sqrt_neg", 1'b0, 1'b1, 64'hC010_0000_0000_0000, 64'd0, 2'b01, 0, fx);
    fx = '{en: 1'b1, ea: 13'd15, ma: 53'd1 << 52, sp: 1'b1, res: 64'h7C00, nv: 1'b0, dz: 1'b1};
    run_op("fp16_div_by0", 1'b1, 1'b0, 64'h3C00, 64'h0000, 2'b10, 0, fx);
    fx = '{en: 1'b1, ea: 13'd0, ma: 53'd0, sp: 1'b1, res: 64'h7E00, nv: 1'b1, dz: 1'b0};
    run_op("fp16_0_div_0", 1'b1, 1'b0, 64'h0000, 64'h0000, 2'b10, 0, fx);
    fx = '{en: 1'b1, ea: 13'd127, ma: 53'd1 << 52, sp: 1'b1, res: 64'h7FC0, nv: 1'b1, dz: 1'b0};
    run_op("fp16alt_sqrt_neg", 1'b0, 1'b1, 64'hBF80, 64'd0, 2'b11, 0, fx);

    run_op("backpressure", 1'b1, 1'b0, 64'h4049_0FDB, 64'h0000_0003, 2'b00, 5, nofix);
    run_op("both_starts", 1'b1, 1'b1, 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000,
           2'b01, 0, nofix);

    kill_test("kill_norm", 0, 1'b0);
    kill_test("kill_out", 1, 1'b0);
    kill_test("kill_norm_both", 0, 1'b1);
    kill_test("kill_out_both", 1, 1'b1);

    kill = 1'b1; div_start = 1'b1;
    @(negedge clk);
    kill = 1'b0; div_start = 1'b0;
    check("kill_idle.ready", 64'(ready), 64'd1);
    @(negedge clk);
    check("kill_idle.stay_ready", 64'(ready), 64'd1);
    check("kill_idle.valid",      64'(out_valid), 64'd0);

    for (int n = 0; n < 300; n++) begin
      logic [1:0] f;
      logic d, s;
      f = 2'($urandom);
      d = 1'($urandom_range(0, 1));
      s = d ? 1'($urandom_range(0, 1)) : 1'b1;
      run_op("rand", d, s, rand_op(f), rand_op(f), f, int'($urandom_range(0, 3)), nofix);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
